// File: rtl/gf2_div_pkg.sv
// Shared types and constants for the carry-less polynomial divider.
package gf2_div_pkg;

  localparam int unsigned DefAW = 512;
  localparam int unsigned DefBW = 256;

  typedef enum logic [1:0] {
    StIdle,
    StDiv,
    StDone
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned a_w);
    return (a_w > 1) ? $clog2(a_w) : 1;
  endfunction

endpackage

// File: rtl/gf2_div_step.sv
// One combinational long-division step over GF(2)[x]: shift in a dividend bit,
// subtract (XOR) the divisor when the aligned leading coefficient is set.
module gf2_div_step
  import gf2_div_pkg::*;
#(
  parameter int unsigned B_W = DefBW,
  parameter int unsigned D_W = 8
) (
  input  logic [B_W-1:0] r_i,
  input  logic           bit_i,
  input  logic [B_W-1:0] divisor_i,
  input  logic [D_W-1:0] d_i,
  output logic [B_W-1:0] r_o,
  output logic           q_o
);

  localparam int unsigned TW = $clog2(B_W + 1);

  logic [B_W:0] t;
  logic         unused_top;

  always_comb begin
    t   = {r_i, bit_i};
    q_o = t[TW'(d_i)];
    if (q_o) begin
      t = t ^ {1'b0, divisor_i};
    end
    r_o = t[B_W-1:0];
  end

  // r always has degree below d, so the shifted-out top bit is never set.
  assign unused_top = t[B_W];

endmodule

// File: rtl/gf2_poly_divider.sv
// Sequential carry-less polynomial divider, MSB-first, one bit per cycle.
// Define GF2_DIV_RADIX4_EN to retire two quotient bits per cycle.
module gf2_poly_divider
  import gf2_div_pkg::*;
#(
  parameter int unsigned A_W = DefAW,
  parameter int unsigned B_W = DefBW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] dividend,
  input  logic [B_W-1:0] divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [A_W-1:0] quotient,
  output logic [B_W-1:0] remainder,
  output logic           div0
);

`ifdef GF2_DIV_RADIX4_EN
  localparam int unsigned Steps = 2;
`else
  localparam int unsigned Steps = 1;
`endif
  localparam int unsigned CW = cnt_width(A_W);
  localparam int unsigned DW = (B_W > 1) ? $clog2(B_W) : 1;
  localparam logic [CW-1:0] CntLoad = CW'(A_W / Steps - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [A_W-1:0] dvd_q, dvd_d;
  logic [B_W-1:0] dvs_q, dvs_d;
  logic [DW-1:0]  d_q, d_d;
  logic [B_W-1:0] r_q, r_d;
  logic [A_W-1:0] q_q, q_d;
  logic           div0_q, div0_d;

  logic [DW-1:0]  msb_idx;
  logic [B_W-1:0] r_s1, r_next;
  logic [A_W-1:0] dvd_next, q_next;
  logic           q_s1;

  always_comb begin
    msb_idx = '0;
    for (int k = 0; k < B_W; k++) begin
      if (divisor[k]) begin
        msb_idx = DW'(k);
      end
    end
  end

  // The dividend register shifts left so the current bit is always its MSB.
  gf2_div_step #(
    .B_W(B_W),
    .D_W(DW)
  ) u_step0 (
    .r_i      (r_q),
    .bit_i    (dvd_q[A_W-1]),
    .divisor_i(dvs_q),
    .d_i      (d_q),
    .r_o      (r_s1),
    .q_o      (q_s1)
  );

`ifdef GF2_DIV_RADIX4_EN
  logic [B_W-1:0] r_s2;
  logic           q_s2;

  gf2_div_step #(
    .B_W(B_W),
    .D_W(DW)
  ) u_step1 (
    .r_i      (r_s1),
    .bit_i    (dvd_q[A_W-2]),
    .divisor_i(dvs_q),
    .d_i      (d_q),
    .r_o      (r_s2),
    .q_o      (q_s2)
  );

  assign r_next   = r_s2;
  assign dvd_next = {dvd_q[A_W-3:0], 2'b00};
  assign q_next   = {q_q[A_W-3:0], q_s1, q_s2};
`else
  assign r_next   = r_s1;
  assign dvd_next = {dvd_q[A_W-2:0], 1'b0};
  assign q_next   = {q_q[A_W-2:0], q_s1};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    d_d     = d_q;
    r_d     = r_q;
    q_d     = q_q;
    div0_d  = div0_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          d_d     = msb_idx;
          r_d     = '0;
          q_d     = '0;
          div0_d  = (divisor == '0);
          cnt_d   = CntLoad;
          state_d = StDiv;
        end
      end
      StDiv: begin
        // A zero divisor spends no step cycles: quotient and remainder stay cleared.
        if (div0_q) begin
          state_d = StDone;
        end else begin
          r_d   = r_next;
          q_d   = q_next;
          dvd_d = dvd_next;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      d_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      d_q     <= d_d;
      r_q     <= r_d;
      q_q     <= q_d;
      div0_q  <= div0_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign quotient  = q_q;
  assign remainder = r_q;
  assign div0      = div0_q;

endmodule

// File: tb/tb_gf2_poly_divider.sv
// Directed and model-checked random tests for gf2_poly_divider.
module tb_gf2_poly_divider;

  localparam int unsigned A_W = 512;
  localparam int unsigned B_W = 256;
`ifdef GF2_DIV_RADIX4_EN
  localparam int Lat = A_W / 2;
`else
  localparam int Lat = A_W;
`endif

  typedef logic [767:0] wide_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [A_W-1:0] dividend;
  logic [B_W-1:0] divisor;
  logic           out_valid;
  logic           out_ready;
  logic [A_W-1:0] quotient;
  logic [B_W-1:0] remainder;
  logic           div0;

  int n_checks = 0;
  int n_err    = 0;

  gf2_poly_divider #(
    .A_W(A_W),
    .B_W(B_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dividend (dividend),
    .divisor  (divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient (quotient),
    .remainder(remainder),
    .div0     (div0)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input wide_t got, input wide_t exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int deg(input logic [B_W-1:0] b);
    int d = -1;
    for (int k = 0; k < B_W; k++) if (b[k]) d = k;
    return d;
  endfunction

  function automatic wide_t clmul(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    wide_t res = '0;
    for (int j = 0; j < B_W; j++) if (b[j]) res = res ^ (wide_t'(a) << j);
    return res;
  endfunction

  // Reference long division: cancel the leading term aligned at x^(i+deg).
  function automatic void div_model(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                                    output logic [A_W-1:0] q, output logic [B_W-1:0] r);
    wide_t rem;
    int    dg;
    q   = '0;
    r   = '0;
    if (b == '0) return;
    dg  = deg(b);
    rem = wide_t'(a);
    for (int i = A_W - 1; i >= 0; i--) begin
      if (rem[i+dg]) begin
        rem  = rem ^ (wide_t'(b) << i);
        q[i] = 1'b1;
      end
    end
    r = rem[B_W-1:0];
  endfunction

  function automatic logic [A_W-1:0] rand_a();
    logic [A_W-1:0] v;
    for (int w = 0; w < A_W / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [B_W-1:0] rand_b();
    logic [B_W-1:0] v;
    for (int w = 0; w < B_W / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic do_op(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                       input logic [A_W-1:0] eq, input logic [B_W-1:0] er, input logic ez,
                       input int elat, input int hold,
                       output logic [A_W-1:0] gq, output logic [B_W-1:0] gr);
    int lat = 0;
    gq = '0;
    gr = '0;
    check_eq("in_ready_idle", wide_t'(in_ready), wide_t'(1));
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = ~a;
    divisor  = ~b;
    check_eq("in_ready_busy", wide_t'(in_ready), wide_t'(0));
    while (!out_valid && lat < elat + 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("latency", wide_t'(lat), wide_t'(elat));
    if (!out_valid) return;
    gq = quotient;
    gr = remainder;
    check_eq("quotient", wide_t'(quotient), wide_t'(eq));
    check_eq("remainder", wide_t'(remainder), wide_t'(er));
    check_eq("div0", wide_t'(div0), wide_t'(ez));
    // Stall the consumer and offer a competing operation that must be ignored.
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      dividend  = a ^ 1;
      divisor   = b ^ 1;
      @(posedge clk);
      #1;
      check_eq("hold_valid", wide_t'(out_valid), wide_t'(1));
      check_eq("hold_in_ready", wide_t'(in_ready), wide_t'(0));
      check_eq("hold_quotient", wide_t'(quotient), wide_t'(eq));
      check_eq("hold_remainder", wide_t'(remainder), wide_t'(er));
      check_eq("hold_div0", wide_t'(div0), wide_t'(ez));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("release_valid", wide_t'(out_valid), wide_t'(0));
    check_eq("release_in_ready", wide_t'(in_ready), wide_t'(1));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic [A_W-1:0] a, eq, gq;
    logic [B_W-1:0] b, er, gr, one, mask;
    logic           seen_valid;
    int             k;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    one       = 1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("rst_out_valid", wide_t'(out_valid), wide_t'(0));
    check_eq("rst_in_ready", wide_t'(in_ready), wide_t'(1));
    check_eq("rst_quotient", wide_t'(quotient), wide_t'(0));
    check_eq("rst_remainder", wide_t'(remainder), wide_t'(0));
    check_eq("rst_div0", wide_t'(div0), wide_t'(0));

    // (x^4+x^2+1)/(x+1) = x^3+x^2 rem 1
    do_op(512'h15, 256'h3, 512'hC, 256'h1, 1'b0, Lat, 2, gq, gr);
    // 0x1B is the carry-less product 0x7*0x5
    do_op(512'h1B, 256'h5, 512'h7, 256'h0, 1'b0, Lat, 0, gq, gr);
    a = rand_a();
    do_op(a, 256'h0, 512'h0, 256'h0, 1'b1, 1, 1, gq, gr);
    a = rand_a();
    do_op(a, 256'h1, a, 256'h0, 1'b0, Lat, 10, gq, gr);
    // Dividend of lower degree than divisor passes straight to the remainder.
    do_op(512'h3, 256'h5, 512'h0, 256'h3, 1'b0, Lat, 0, gq, gr);
    // Full-width divisor divided by itself.
    b = {1'b1, 254'h0, 1'b1};
    do_op({256'h0, b}, b, 512'h1, 256'h0, 1'b0, Lat, 0, gq, gr);

    // Abort mid-division; no result may surface afterwards.
    dividend = 512'h15;
    divisor  = 256'h3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check_eq("abort_valid_in_rst", wide_t'(out_valid), wide_t'(0));
    check_eq("abort_quotient", wide_t'(quotient), wide_t'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("abort_in_ready", wide_t'(in_ready), wide_t'(1));
    seen_valid = 1'b0;
    for (int c = 0; c < Lat + 20; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen_valid = 1'b1;
    end
    check_eq("abort_no_valid", wide_t'(seen_valid), wide_t'(0));
    do_op(512'h15, 256'h3, 512'hC, 256'h1, 1'b0, Lat, 0, gq, gr);

    for (int t = 0; t < 40; t++) begin
      a    = rand_a();
      b    = rand_b();
      k    = (t < 8) ? t : int'($urandom_range(0, B_W - 1));
      mask = (one << (k + 1)) - one;
      b    = b & mask;
      b[k] = 1'b1;
      div_model(a, b, eq, er);
      do_op(a, b, eq, er, 1'b0, Lat, int'($urandom_range(0, 3)), gq, gr);
      check_eq("clmul_identity", clmul(gq, b) ^ wide_t'(gr), wide_t'(a));
      check_eq("rem_degree", wide_t'(gr >> k), '0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
